// File: rtl/seq_mult_core_pkg.sv
// Shared types for the sequential sign-magnitude multiplier: FSM state encoding and
// the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must hold 0..WIDTH, hence WIDTH+1 distinct values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_core_if.sv
// Start/busy/done handshake plus operand and result bus of seq_mult_core.
// The requester uses the master modport and the multiplier core uses the slave modport.
interface seq_mult_core_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 sign;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, product, sign
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, product, sign
    );
endinterface

// File: rtl/seq_mult_core_sm_abs.sv
// Converts an operand into an unsigned magnitude and a negative flag.
// In unsigned mode the operand passes through unchanged.
module sm_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] magnitude,
    output logic             neg
);
    assign neg       = is_signed & value[WIDTH-1];
    // Negating -2^(WIDTH-1) yields 2^(WIDTH-1), which still fits as an unsigned magnitude.
    assign magnitude = neg ? -value : value;
endmodule

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier that produces a sign-magnitude result.
// Defining EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are all zero.
module seq_mult_core
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_mult_core_if.slave   bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 pend_sign_q, pend_sign_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 sign_q, sign_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 neg_a, neg_b;
    logic [2*WIDTH-1:0]   acc_add;
    logic                 early_stop;

    sm_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value     (bus.multiplicand),
        .is_signed (bus.is_signed),
        .magnitude (mag_a),
        .neg       (neg_a)
    );

    sm_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value     (bus.multiplier),
        .is_signed (bus.is_signed),
        .magnitude (mag_b),
        .neg       (neg_b)
    );

    assign acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef EARLY_TERM_EN
    assign early_stop = (mplier_q == '0);
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        pend_sign_d = pend_sign_q;
        product_d   = product_q;
        sign_d      = sign_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    mcand_d     = {{WIDTH{1'b0}}, mag_a};
                    mplier_d    = mag_b;
                    acc_d       = '0;
                    count_d     = '0;
                    pend_sign_d = neg_a ^ neg_b;
                end
            end
            RUN: begin
                if (early_stop) begin
                    state_d   = DONE;
                    product_d = acc_q;
                    sign_d    = pend_sign_q & (acc_q != '0);
                end else begin
                    acc_d    = acc_add;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CNT_W'(1);
                    // The result is published in the same cycle as the final partial-product add.
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d   = DONE;
                        product_d = acc_add;
                        sign_d    = pend_sign_q & (acc_add != '0);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            pend_sign_q <= 1'b0;
            product_q   <= '0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            pend_sign_q <= pend_sign_d;
            product_q   <= product_d;
            sign_q      <= sign_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;
    assign bus.sign    = sign_q;
endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core. It uses WIDTH=8 and WIDTH=4 instances, directed
// cases and random cases checked against an integer-arithmetic reference model.
module tb_seq_mult_core;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    longint last_prod8 = 0, last_prod4 = 0;
    bit     last_sign8 = 0, last_sign4 = 0;

    seq_mult_core_if #(.WIDTH(8)) if8 ();
    seq_mult_core_if #(.WIDTH(4)) if4 ();

    seq_mult_core #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    seq_mult_core #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: signed integer multiply, then split into magnitude, sign and RUN-cycle count.
    function automatic void ref_model(input int w, input logic [7:0] a, input logic [7:0] b,
                                      input bit sg, output longint prod, output bit neg,
                                      output int lat);
        longint mask, av, bv, p, mb;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (sg && a[w-1]) av = av - (longint'(1) << w);
        if (sg && b[w-1]) bv = bv - (longint'(1) << w);
        p    = av * bv;
        neg  = (p < 0);
        prod = neg ? -p : p;
        mb   = (bv < 0) ? -bv : bv;
        lat  = w;
`ifdef EARLY_TERM_EN
        if (mb == 0) lat = 1;
        else begin
            int msb = 0;
            for (int i = 0; i < w; i++) if (mb[i]) msb = i;
            lat = (msb + 2 < w) ? msb + 2 : w;
        end
`endif
    endfunction

    task automatic drive(input int w, input bit st, input bit sg, input logic [7:0] a,
                         input logic [7:0] b);
        if (w == 8) begin
            if8.start = st; if8.is_signed = sg; if8.multiplicand = a; if8.multiplier = b;
        end else begin
            if4.start = st; if4.is_signed = sg; if4.multiplicand = a[3:0]; if4.multiplier = b[3:0];
        end
    endtask

    function automatic longint obs_busy(input int w);
        return (w == 8) ? longint'(if8.busy) : longint'(if4.busy);
    endfunction
    function automatic longint obs_done(input int w);
        return (w == 8) ? longint'(if8.done) : longint'(if4.done);
    endfunction
    function automatic longint obs_prod(input int w);
        return (w == 8) ? longint'(if8.product) : longint'(if4.product);
    endfunction
    function automatic longint obs_sign(input int w);
        return (w == 8) ? longint'(if8.sign) : longint'(if4.sign);
    endfunction

    // One full operation. A start pulse can be injected mid-RUN at iteration glitch_n (-1 = none).
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input bit sg,
                          input string tag, input int glitch_n);
        longint ep, pp;
        bit     es, ps;
        int     lat;
        ref_model(w, a, b, sg, ep, es, lat);
        pp = (w == 8) ? last_prod8 : last_prod4;
        ps = (w == 8) ? last_sign8 : last_sign4;
        @(negedge clk);
        drive(w, 1'b1, sg, a, b);
        @(posedge clk);
        #1 drive(w, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        for (int n = 0; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == glitch_n)
                drive(w, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            else if (n == glitch_n + 1)
                drive(w, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
            check($sformatf("%s busy c%0d", tag, n), obs_busy(w), longint'(n < lat));
            check($sformatf("%s done c%0d", tag, n), obs_done(w), longint'(n == lat));
            if (n < lat) begin
                check($sformatf("%s hold_prod c%0d", tag, n), obs_prod(w), pp);
                check($sformatf("%s hold_sign c%0d", tag, n), obs_sign(w), longint'(ps));
            end else begin
                check($sformatf("%s product", tag), obs_prod(w), ep);
                check($sformatf("%s sign", tag), obs_sign(w), longint'(es));
            end
        end
        if (w == 8) begin last_prod8 = ep; last_sign8 = es; end
        else        begin last_prod4 = ep; last_sign4 = es; end
    endtask

    initial begin
        drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
        #12;
        check("reset busy8", obs_busy(8), 0);
        check("reset done8", obs_done(8), 0);
        check("reset prod8", obs_prod(8), 0);
        check("reset sign4", obs_sign(4), 0);
        @(negedge clk);
        rst = 1'b1;

        run_op(8, 8'd5,  8'd3,  1'b0, "u5x3", -1);
        run_op(8, 8'hFF, 8'hFF, 1'b0, "uFFxFF", -1);
        run_op(8, 8'h80, 8'h80, 1'b1, "s80x80", -1);
        run_op(8, 8'hF9, 8'h06, 1'b1, "sm7x6", -1);
        run_op(8, 8'h00, 8'hFB, 1'b1, "s0xm5", -1);
        run_op(8, 8'h03, 8'h01, 1'b0, "u3x1", -1);
        run_op(8, 8'h23, 8'h9C, 1'b0, "ignore_start", 2);
        run_op(4, 8'h08, 8'h07, 1'b1, "w4_sm8x7", -1);

        // Abort mid-operation, then confirm the core restarts cleanly.
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 8'd200, 8'd201);
        @(posedge clk);
        #1 drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst busy", obs_busy(8), 0);
        check("midrst done", obs_done(8), 0);
        check("midrst prod", obs_prod(8), 0);
        check("midrst prod4", obs_prod(4), 0);
        check("midrst sign", obs_sign(8), 0);
        @(negedge clk);
        rst = 1'b1;
        last_prod8 = 0; last_sign8 = 0; last_prod4 = 0; last_sign4 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst no_done", obs_done(8), 0);
        end
        run_op(8, 8'h12, 8'h34, 1'b0, "restart", -1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (i % 8 == 0) ? 8'h00 : 8'($urandom);
            run_op(8, ra, rb, 1'($urandom), $sformatf("rnd8_%0d", i), -1);
        end
        for (int i = 0; i < 20; i++)
            run_op(4, 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd4_%0d", i), -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
